// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_fetch_pkg;

  // Fetch-stage control state: fetching, parked on BREAK, or dead on a bad target.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_WORD   = 32'h0000_0000;
  localparam logic [31:0] BREAK_WORD = 32'h0000_000D;

  // A byte address is usable as a fetch target only if it names a whole word.
  function automatic logic isWordAligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Bus between the fetch stage and its controller / program loader.
// The master drives control and program-load signals; the slave (the fetch
// unit) returns the fetched instruction and status.
interface mips_fetch_unit_if #(
  parameter int ADDR_W = 8
);

  logic              stall;
  logic              redirect;
  logic [31:0]       redirect_target;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [31:0]       imem_wdata;
  logic [31:0]       instruction;
  logic [31:0]       pc;
  logic [31:0]       pc_plus4;
  logic              valid;
  logic              halted;
  logic              misaligned;

  modport master (
    output stall, redirect, redirect_target, imem_we, imem_waddr, imem_wdata,
    input  instruction, pc, pc_plus4, valid, halted, misaligned
  );

  modport slave (
    input  stall, redirect, redirect_target, imem_we, imem_waddr, imem_wdata,
    output instruction, pc, pc_plus4, valid, halted, misaligned
  );

endinterface

// File: rtl/mips_imem.sv
// Instruction memory: one synchronous write port and a combinational read
// port. The consumer registers the read data on the same edge a write may
// land, so a same-address read in that cycle sees the old word.
module mips_imem #(
  parameter int IMEM_DEPTH = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clock,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [IMEM_DEPTH];

  // Program-load write; deliberately independent of reset so code can be
  // loaded while the fetch stage is held in reset.
  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: holds the fetch PC, reads the instruction memory
// and presents one registered instruction per clock to the CPU, with stall,
// redirect/squash, halt on BREAK and a sticky fault on misaligned targets.
module mips_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int          IMEM_DEPTH = 256,
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input logic              clock,
  input logic              reset,
  mips_fetch_unit_if.slave bus
);

  fetch_state_t state_q;
  logic [31:0]  fetchPc_q;
  logic [31:0]  instr_q;
  logic [31:0]  pc_q;
  logic [31:0]  pcPlus4_q;
  logic         valid_q;
  logic         halted_q;
  logic         misaligned_q;

  logic [31:0]  fetchWord_d;
  logic [31:0]  fetchPcPlus4_d;

  mips_imem #(
    .IMEM_DEPTH(IMEM_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_imem (
    .clock  (clock),
    .we_i   (bus.imem_we),
    .waddr_i(bus.imem_waddr),
    .wdata_i(bus.imem_wdata),
    .raddr_i(fetchPc_q[ADDR_W+1:2]),
    .rdata_o(fetchWord_d)
  );

  assign fetchPcPlus4_d = fetchPc_q + 32'd4;

  // Fetch FSM and output registers; priority is reset, then redirect, then
  // the halted park, then stall, then a normal fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= RUN;
      fetchPc_q    <= RESET_PC;
      instr_q      <= NOP_WORD;
      pc_q         <= 32'd0;
      pcPlus4_q    <= 32'd4;
      valid_q      <= 1'b0;
      halted_q     <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (state_q != FAULT) begin
      if (bus.redirect) begin
        instr_q  <= NOP_WORD;
        valid_q  <= 1'b0;
        halted_q <= 1'b0;
        if (isWordAligned(bus.redirect_target)) begin
          fetchPc_q <= bus.redirect_target;
          state_q   <= RUN;
        end else begin
          misaligned_q <= 1'b1;
          state_q      <= FAULT;
        end
      end else if (state_q == HALTED) begin
        instr_q <= NOP_WORD;
        valid_q <= 1'b0;
      end else if (!bus.stall) begin
        instr_q   <= fetchWord_d;
        pc_q      <= fetchPc_q;
        pcPlus4_q <= fetchPcPlus4_d;
        valid_q   <= 1'b1;
        if (fetchWord_d == BREAK_WORD) begin
          state_q  <= HALTED;
          halted_q <= 1'b1;
        end else begin
          fetchPc_q <= fetchPcPlus4_d;
        end
      end
    end
  end

  assign bus.instruction = instr_q;
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pcPlus4_q;
  assign bus.valid       = valid_q;
  assign bus.halted      = halted_q;
  assign bus.misaligned  = misaligned_q;

endmodule
